// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the clk5-domain reset sequencer.
// Holds the FSM state encoding and the width helpers used at elaboration.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_SOFT = 2'd3
    } seq_state_t;

    localparam int N_STAGES_MIN = 1;
    localparam int N_STAGES_MAX = 8;
    localparam int HOLD_MIN     = 1;
    localparam int HOLD_MAX     = 65535;

    function automatic int cnt_width(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

    function automatic int idx_width(input int n_stages);
        return (n_stages > 1) ? $clog2(n_stages) : 1;
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on clk5.
// Reusable by any block that needs a clean clk5-domain reset.
module reset_sync (
    input  logic clk5,
    input  logic reset,
    output logic rst_s
);

    logic meta;

    // Shift zeros in once reset drops; any reset pulse sets both flops at once
    always_ff @(posedge clk5 or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            rst_s <= 1'b1;
        end else begin
            meta  <= 1'b0;
            rst_s <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Releases staged subsystem resets in order after a synchronised reset,
// with a req/ack soft reset that reruns the whole sequence from RUN.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES    = 3,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                clk5,
    input  logic                reset,
    input  logic                soft_rst_req,
    output logic                soft_rst_ack,
    output logic [N_STAGES-1:0] stage_rst,
    output logic                all_ready,
    output logic                busy
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES);
    localparam int IDX_W = idx_width(N_STAGES);

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST =
        IDX_W'(N_STAGES - 1);

    if (N_STAGES < N_STAGES_MIN ||
        N_STAGES > N_STAGES_MAX) begin : g_bad_stages
        $error("reset_sequencer: N_STAGES out of range");
    end

    if (HOLD_CYCLES < HOLD_MIN ||
        HOLD_CYCLES > HOLD_MAX) begin : g_bad_hold
        $error("reset_sequencer: HOLD_CYCLES out of range");
    end

    logic                rst_s;
    seq_state_t          state_q;
    seq_state_t          state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [N_STAGES-1:0] stage_q;
    logic [N_STAGES-1:0] stage_d;
    logic                pend_q;
    logic                pend_d;
    logic                ack_q;
    logic                ack_d;
    logic                cnt_last;
    logic                idx_last;

    reset_sync u_reset_sync (
        .clk5  (clk5),
        .reset (reset),
        .rst_s (rst_s)
    );

    assign cnt_last = (cnt_q == CNT_LAST);
    assign idx_last = (idx_q == IDX_LAST);

    // State and output registers; rst_s carries the asynchronous assertion
    always_ff @(posedge clk5 or posedge rst_s) begin
        if (rst_s) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '1;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
        end
    end

    // Next state, gap counter and stage index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_HOLD: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rst_s) begin
                    state_d = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (idx_last) begin
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    state_d = ST_SOFT;
                    cnt_d   = '0;
                end
            end
            ST_SOFT: begin
                if (cnt_last) begin
                    state_d = ST_SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    // Stage release, soft-reset bookkeeping and status flags
    always_comb begin
        stage_d   = stage_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        all_ready = (state_q == ST_RUN);
        busy      = (state_q != ST_RUN);
        unique case (state_q)
            ST_HOLD: begin
                stage_d = '1;
            end
            ST_SEQ: begin
                if (cnt_last) begin
                    for (int i = 0; i < N_STAGES; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            stage_d[i] = 1'b0;
                        end
                    end
                    if (idx_last) begin
                        ack_d  = pend_q;
                        pend_d = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (soft_rst_req) begin
                    stage_d = '1;
                    pend_d  = 1'b1;
                end
            end
            ST_SOFT: begin
                stage_d = '1;
            end
            default: begin
                stage_d = '1;
            end
        endcase
    end

    assign stage_rst    = stage_q;
    assign soft_rst_ack = ack_q;

endmodule
